decoding_stage_controller: RTL
==============================

Name: decoding_stage_controller

Overview:
- Central sequencer that drives `global_stage` to every processing unit of the single-FPGA union-find decoder.
- Runs measurement load, then repeated grow/merge rounds until no cluster is odd, then peeling, then result handoff.
- Handles context save/restore when more than one context is configured.
- Observes the PE array's aggregated `busy` and `odd` flags and tells the PE array when the merge stage has converged.

Parameters:
- PE_COUNT, 16, number of processing units observed (width of busy_vec/odd_vec).
- NUM_CONTEXTS, 2, contexts time-multiplexed on the PE array; 1 disables save/restore.
- GROW_CYCLES, 2, cycles `global_stage` is held at STAGE_GROW.
- MERGE_MIN_CYCLES, 3, minimum MERGE cycles before exit is considered; covers the 2-cycle PE stage/busy register lag.
- MERGE_QUIET_CYCLES, 2, consecutive all-idle cycles required to leave MERGE.
- MAX_GROW_ITER, 63, grow/merge rounds before the error abort.
- MEM_LATENCY, 2, idle cycles between WRITE_TO_MEM and READ_FROM_MEM.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- meas_valid  input  1  new syndrome round is available at the PE measurement inputs
- meas_ready  output  1  one-cycle pulse; the round was sampled (LOADING cycle)
- busy_vec  input  PE_COUNT  per-PE busy
- odd_vec  input  PE_COUNT  per-PE odd
- global_stage  output  STAGE_WIDTH  stage broadcast to all PEs
- context_id  output  $clog2(NUM_CONTEXTS) or 1  context currently resident
- iter_count  output  8  grow rounds of the current decode
- result_valid  output  1  peeling done; correction outputs of the PEs are stable
- result_ready  input  1  consumer accepts the result
- iter_overflow  output  1  sticky per decode; MAX_GROW_ITER was reached
- decode_cycles  output  16  present only with CYCLE_COUNTER_EN

Behaviour:
- Reset values: `global_stage`=STAGE_IDLE, `context_id`=0, `iter_count`=0, all 1-bit outputs 0. Reset mid-operation aborts immediately to these values.
- FSM states (one `global_stage` value each): IDLE, PREP, LOAD, GROW, MERGE, PEEL, RESULT, WR_MEM, MEM_WAIT, RD_MEM. `global_stage` is a registered output.
- IDLE: stays until `meas_valid`=1. If `context_id`==0, go to PREP; otherwise go directly to LOAD, because PREP resets the PE memory address.
- PREP: 1 cycle, then LOAD.
- LOAD: 1 cycle; `meas_ready`=1 in this cycle only. Clear `iter_count` and `iter_overflow`. Then GROW.
- GROW: held exactly GROW_CYCLES cycles, then MERGE.
- MERGE:
  - Stage counter increments every cycle.
  - Quiet counter increments when `busy_vec`==0 and resets to 0 on any busy bit.
  - Exit when stage counter ≥ MERGE_MIN_CYCLES-1 and quiet counter ≥ MERGE_QUIET_CYCLES.
- Exit decision, using `odd_vec` sampled in the exit cycle:
  - `|odd_vec`=0 → PEEL.
  - Otherwise `iter_count`++. If the new value equals MAX_GROW_ITER, set `iter_overflow` and go to PEEL; else go to GROW.
  - `iter_count` saturates at 255.
- PEEL: 1 cycle, then RESULT.
- RESULT: `global_stage` held at STAGE_PEELING so PE error outputs stay valid; `result_valid`=1.
  - Leave on the first cycle with `result_ready`=1.
  - `result_valid` drops the following cycle.
  - If NUM_CONTEXTS==1, go to IDLE; else go to WR_MEM.
- WR_MEM: 1 cycle, then MEM_WAIT.
- MEM_WAIT: `global_stage`=STAGE_IDLE for MEM_LATENCY cycles, then RD_MEM.
- RD_MEM: 1 cycle. `context_id` ← (`context_id`+1) mod NUM_CONTEXTS, wrapping to 0. Then IDLE.
- `meas_valid` is ignored outside IDLE. A `meas_valid` that rises in the same cycle as the return to IDLE is honoured the next cycle.
- Counter rules: all counters are sized with $clog2 of their parameter plus 1 and never wrap before their compare.

Optional Feature:
- Macro: CYCLE_COUNTER_EN.
- Defined: `decode_cycles` clears in LOAD, increments every cycle through PEEL (saturating at 16'hFFFF), and freezes in RESULT.
- Undefined: the port and the counter are absent.

Decomposition:
- Shared package holds:
  - STAGE_WIDTH=4.
  - Stage constants: STAGE_IDLE=0, STAGE_GROW=1, STAGE_MERGE=2, STAGE_PEELING=3, STAGE_MEASUREMENT_PREPARING=4, STAGE_MEASUREMENT_LOADING=5, STAGE_RESULT_VALID=6, STAGE_READ_FROM_MEM=7, STAGE_WRITE_TO_MEM=8.
  - The FSM state enum.
- Sub-module `merge_quiet_detector`: contains the stage counter and quiet counter, and outputs a single `merge_done`.

Test Plan:
- Single odd defect, `busy_vec` clears 1 cycle after MERGE starts, `odd_vec`=0 after the first merge → sequence PREP, LOAD, GROW×2, MERGE×3, PEEL, RESULT; `iter_count`=1? No: `iter_count`=0 since no odd remains after the first merge; `meas_ready` asserted exactly once.
- `odd_vec`≠0 for 3 merges then 0 → 4 GROW entries, `iter_count`=3, `iter_overflow`=0.
- `busy_vec` toggling 1,0,1,0,0 in MERGE → exit only after the final two zeros.
- `odd_vec` stuck at 1 with MAX_GROW_ITER=4 → `iter_overflow`=1 and PEEL is entered after round 4.
- NUM_CONTEXTS=2, two decodes:
  - Decode 1 visits PREP; decode 2 skips PREP.
  - WR_MEM, MEM_WAIT×2, RD_MEM occur between decodes.
  - `context_id` reads 0→1→0.
- `reset` asserted in MERGE → next cycle `global_stage`=STAGE_IDLE, all outputs at reset values; a following `meas_valid` starts a fresh decode.

Source files
------------

// File: rtl/decoding_stage_controller_pkg.sv
// Shared stage encoding and FSM state type for the union-find decoding stage controller.
package decoding_stage_controller_pkg;

  localparam int STAGE_WIDTH = 4;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                  = 4'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                  = 4'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE                 = 4'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING               = 4'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_PREPARING = 4'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING   = 4'd5;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID          = 4'd6;
  localparam logic [STAGE_WIDTH-1:0] STAGE_READ_FROM_MEM         = 4'd7;
  localparam logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM          = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE, ST_PREP, ST_LOAD, ST_GROW, ST_MERGE,
    ST_PEEL, ST_RESULT, ST_WR_MEM, ST_MEM_WAIT, ST_RD_MEM
  } fsm_state_e;

  // RESULT keeps the PEs in peeling so their correction outputs stay valid.
  function automatic logic [STAGE_WIDTH-1:0] stage_of(fsm_state_e s);
    case (s)
      ST_PREP:   return STAGE_MEASUREMENT_PREPARING;
      ST_LOAD:   return STAGE_MEASUREMENT_LOADING;
      ST_GROW:   return STAGE_GROW;
      ST_MERGE:  return STAGE_MERGE;
      ST_PEEL:   return STAGE_PEELING;
      ST_RESULT: return STAGE_PEELING;
      ST_WR_MEM: return STAGE_WRITE_TO_MEM;
      ST_RD_MEM: return STAGE_READ_FROM_MEM;
      default:   return STAGE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/decoding_stage_controller_merge_quiet_detector.sv
// Decides when the MERGE stage has converged: minimum dwell plus a run of all-idle PE cycles.
module merge_quiet_detector #(
  parameter int MERGE_MIN_CYCLES   = 3,
  parameter int MERGE_QUIET_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic busy_any,
  output logic merge_done
);

  localparam int STAGE_W = $clog2(MERGE_MIN_CYCLES) + 1;
  localparam int QUIET_W = $clog2(MERGE_QUIET_CYCLES) + 1;
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(MERGE_MIN_CYCLES - 1);
  localparam logic [QUIET_W-1:0] QUIET_NEED = QUIET_W'(MERGE_QUIET_CYCLES);

  logic [STAGE_W-1:0] stage_cnt;
  logic [QUIET_W-1:0] quiet_cnt;
  logic [QUIET_W-1:0] quiet_now;

  // The current cycle's idle flag counts toward the quiet run.
  always_comb begin
    quiet_now = '0;
    if (!busy_any)
      quiet_now = (quiet_cnt == QUIET_NEED) ? quiet_cnt : quiet_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || !active) begin
      stage_cnt <= '0;
      quiet_cnt <= '0;
    end else begin
      if (stage_cnt != STAGE_LAST)
        stage_cnt <= stage_cnt + 1'b1;
      quiet_cnt <= quiet_now;
    end
  end

  assign merge_done = active && (stage_cnt >= STAGE_LAST) && (quiet_now >= QUIET_NEED);

endmodule

// File: rtl/decoding_stage_controller.sv
// Stage sequencer for the union-find decoder PE array; optional CYCLE_COUNTER_EN adds decode_cycles.
// state     | meaning
// IDLE      | wait for meas_valid
// PREP      | reset PE memory address (context 0 only)
// LOAD      | sample syndrome round, clear iteration state
// GROW      | cluster growth, GROW_CYCLES long
// MERGE     | wait for PE array to settle, then check odd clusters
// PEEL      | one peeling cycle
// RESULT    | hold peeling outputs until result_ready
// WR_MEM    | save context
// MEM_WAIT  | memory latency
// RD_MEM    | restore next context
module decoding_stage_controller
  import decoding_stage_controller_pkg::*;
#(
  parameter int PE_COUNT           = 16,
  parameter int NUM_CONTEXTS       = 2,
  parameter int GROW_CYCLES        = 2,
  parameter int MERGE_MIN_CYCLES   = 3,
  parameter int MERGE_QUIET_CYCLES = 2,
  parameter int MAX_GROW_ITER      = 63,
  parameter int MEM_LATENCY        = 2,
  localparam int CTX_W = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   meas_valid,
  output logic                   meas_ready,
  input  logic [PE_COUNT-1:0]    busy_vec,
  input  logic [PE_COUNT-1:0]    odd_vec,
  output logic [STAGE_WIDTH-1:0] global_stage,
  output logic [CTX_W-1:0]       context_id,
  output logic [7:0]             iter_count,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   iter_overflow
`ifdef CYCLE_COUNTER_EN
  ,
  output logic [15:0]            decode_cycles
`endif
);

  localparam int TMR_MAX = (GROW_CYCLES > MEM_LATENCY) ? GROW_CYCLES : MEM_LATENCY;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  fsm_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q;
  logic [7:0]       iter_next;
  logic             iter_hits_max;
  logic             any_odd;
  logic             merge_active;
  logic             merge_done;

  assign any_odd       = |odd_vec;
  assign iter_next     = (iter_count == 8'hFF) ? 8'hFF : iter_count + 8'd1;
  assign iter_hits_max = (int'(iter_next) == MAX_GROW_ITER);

  merge_quiet_detector #(
    .MERGE_MIN_CYCLES   (MERGE_MIN_CYCLES),
    .MERGE_QUIET_CYCLES (MERGE_QUIET_CYCLES)
  ) u_merge_quiet (
    .clk        (clk),
    .reset      (reset),
    .active     (merge_active),
    .busy_any   (|busy_vec),
    .merge_done (merge_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      global_stage <= STAGE_IDLE;
    end else begin
      state_q      <= state_d;
      global_stage <= stage_of(state_d);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (meas_valid) state_d = (context_id == '0) ? ST_PREP : ST_LOAD;
      ST_PREP:     state_d = ST_LOAD;
      ST_LOAD:     state_d = ST_GROW;
      ST_GROW:     if (timer_q == '0) state_d = ST_MERGE;
      ST_MERGE:    if (merge_done) state_d = (!any_odd || iter_hits_max) ? ST_PEEL : ST_GROW;
      ST_PEEL:     state_d = ST_RESULT;
      ST_RESULT:   if (result_ready) state_d = (NUM_CONTEXTS == 1) ? ST_IDLE : ST_WR_MEM;
      ST_WR_MEM:   state_d = (MEM_LATENCY == 0) ? ST_RD_MEM : ST_MEM_WAIT;
      ST_MEM_WAIT: if (timer_q == '0) state_d = ST_RD_MEM;
      ST_RD_MEM:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    meas_ready   = (state_q == ST_LOAD);
    result_valid = (state_q == ST_RESULT);
    merge_active = (state_q == ST_MERGE);
  end

  // Shared dwell timer, loaded with length-1 on entry; the state leaves on terminal count.
  always_ff @(posedge clk) begin
    if (reset)
      timer_q <= '0;
    else if (state_d == ST_GROW && state_q != ST_GROW)
      timer_q <= TMR_W'(GROW_CYCLES - 1);
    else if (state_d == ST_MEM_WAIT && state_q != ST_MEM_WAIT)
      timer_q <= TMR_W'(MEM_LATENCY - 1);
    else if (timer_q != '0)
      timer_q <= timer_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || state_q == ST_LOAD) begin
      iter_count    <= '0;
      iter_overflow <= 1'b0;
    end else if (merge_active && merge_done && any_odd) begin
      iter_count <= iter_next;
      if (iter_hits_max)
        iter_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      context_id <= '0;
    else if (state_q == ST_RD_MEM)
      context_id <= (context_id == CTX_W'(NUM_CONTEXTS - 1)) ? '0 : context_id + 1'b1;
  end

`ifdef CYCLE_COUNTER_EN
  always_ff @(posedge clk) begin
    if (reset || state_q == ST_LOAD)
      decode_cycles <= '0;
    else if ((state_q == ST_GROW || state_q == ST_MERGE || state_q == ST_PEEL) &&
             decode_cycles != 16'hFFFF)
      decode_cycles <= decode_cycles + 16'd1;
  end
`endif

endmodule
